otp_pad_engine: RTL
===================

Name: otp_pad_engine

Overview:
- Parametrised one-time-pad encrypt/decrypt engine with valid/ready handshakes on input and output.
- Generalises the 8-bit/8-entry OTP encryptor in data width, pad depth and LFSR polynomial.
- Enforces true one-time use: a pad is destroyed after one decrypt, and accesses to empty slots are flagged.
- Sits between the tile's byte I/O adapter and the user pins; the adapter maps pins to the handshake ports.

Parameters:
- DATA_W, 8, data, pad and LFSR width in bits (4..32).
- DEPTH, 8, number of pad slots; power of two, 2..64.
- LFSR_POLY, 8'hB8, Galois feedback tap mask, DATA_W bits wide.
- LFSR_SEED, 8'h5A, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; when 0, no transaction is accepted and all state holds.
- flush  in  1  synchronous wipe of all pad slots.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
- in_idx  in  IDX_W  slot to decrypt with, where IDX_W = $clog2(DEPTH); ignored on encrypt.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  result data; 0 when out_err = 1.
- out_idx  out  IDX_W  slot written (encrypt) or slot read (decrypt).
- out_err  out  1  encrypt while full, or decrypt of an empty slot.
- pad_count  out  $clog2(DEPTH+1)  number of occupied slots.
- full  out  1  pad_count == DEPTH.

Behaviour:
- Reset (async, rst_n = 0):
  - out_valid = 0, out_data = 0, out_idx = 0, out_err = 0.
  - All slot valid bits = 0 and all pad storage = 0.
  - pad_count = 0, LFSR = LFSR_SEED.
- Handshake:
  - in_ready = ena && !flush && (!out_valid || out_ready).
  - At most one transaction per cycle.
  - Latency is 1 cycle: the result is registered on the edge where the request is accepted.
  - out_* outputs hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new request is accepted on the same edge.
- Encrypt, not full:
  - Target slot s = lowest-index slot with valid = 0.
  - pad = current LFSR state; out_data = in_data ^ pad.
  - mem[s] <= pad, valid[s] <= 1, out_idx = s, out_err = 0.
  - LFSR advances one step; pad_count increments.
- Encrypt, full:
  - out_err = 1, out_data = 0, out_idx = 0.
  - LFSR does not advance; no slot changes.
- Decrypt, valid[in_idx] = 1:
  - out_data = in_data ^ mem[in_idx], out_idx = in_idx, out_err = 0.
  - mem[in_idx] <= 0, valid[in_idx] <= 0, pad_count decrements.
- Decrypt, valid[in_idx] = 0:
  - out_err = 1, out_data = 0, out_idx = in_idx; no state change.
- LFSR:
  - Galois form: next = (s >> 1) ^ (s[0] ? LFSR_POLY : 0).
  - Advances only on an accepted, non-error encrypt; it is not free-running.
  - Never reaches 0 from a nonzero seed.
- Slot allocation: freed slots are reused lowest-first, so allocation order is not round-robin.
- flush = 1:
  - On the next edge, all valid bits and pads are cleared and pad_count = 0.
  - in_ready = 0 during flush, so no transaction coincides with it.
  - An in-flight out_* result is unaffected; LFSR holds.
- ena = 0:
  - in_ready = 0.
  - A pending output still completes on out_ready.
- Reset mid-operation: any pending result is discarded (out_valid = 0) and all pads are lost.
- Widths: pad_count never wraps; the full and error rules guarantee 0 <= pad_count <= DEPTH.

Decomposition:
- Package otp_pkg:
  - mode constants OTP_ENC = 1'b0 and OTP_DEC = 1'b1.
  - default LFSR_POLY/LFSR_SEED values for DATA_W 8, 16 and 32.
  - helper function for the Galois LFSR next state.
- Sub-module otp_free_slot_enc: parametrised lowest-free-slot priority encoder.
  - Input: DEPTH valid bits.
  - Outputs: IDX_W index and any_free.
- The LFSR is inline in the top level, using the package function.

Test Plan:
- Reset with defaults, then encrypt in_data = 8'h3C with out_ready = 1 → next cycle out_valid = 1, out_data = 8'h66 (3C ^ 5A), out_idx = 0, out_err = 0, pad_count = 1.
- Decrypt in_idx = 0, in_data = 8'h66 → out_data = 8'h3C, out_err = 0, pad_count = 0. Repeat the same decrypt → out_err = 1, out_data = 8'h00.
- Issue 8 encrypts → out_idx values 0..7, full = 1. 9th encrypt → out_err = 1, and the LFSR is unchanged: a following decrypt then encrypt yields the expected next pad in the freed slot.
- Fill slots 0..3, decrypt slot 1, then encrypt → out_idx = 1, pad_count = 4.
- Hold out_ready = 0 after an encrypt → in_ready = 0, and out_data/out_idx stay stable for 5 cycles. Raise out_ready → single completion, in_ready = 1.
- Load 3 pads, then pulse flush → pad_count = 0, and decrypts of slots 0..2 all give out_err = 1. Separately, assert rst_n = 0 while out_valid = 1 → out_valid = 0 immediately, LFSR = 8'h5A.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared constants and the Galois LFSR step for the one-time-pad engine.
package otp_pkg;

  localparam logic OTP_ENC = 1'b0;
  localparam logic OTP_DEC = 1'b1;

  // Maximal-length tap masks and nonzero seeds for the common widths.
  localparam logic [7:0]  OTP_POLY_8  = 8'hB8;
  localparam logic [7:0]  OTP_SEED_8  = 8'h5A;
  localparam logic [15:0] OTP_POLY_16 = 16'hB400;
  localparam logic [15:0] OTP_SEED_16 = 16'hACE1;
  localparam logic [31:0] OTP_POLY_32 = 32'h8020_0003;
  localparam logic [31:0] OTP_SEED_32 = 32'h0000_0001;

  // Operands are zero-extended to 32 bits; the upper bits stay zero because
  // the tap mask is no wider than the state, so callers just truncate.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] poly);
    return (state >> 1) ^ (state[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/otp_free_slot_enc.sv
// Priority encoder: index of the lowest-numbered slot whose valid bit is clear.
module otp_free_slot_enc #(
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_bits,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a signal unassigned and no latch is inferred.
    free_idx = '0;
    any_free = 1'b0;
    // Scanning high-to-low lets the lowest free slot overwrite the others.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_bits[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/otp_pad_engine.sv
// One-time-pad encrypt/decrypt engine: LFSR-generated pads stored in slots,
// each pad destroyed after a single decrypt. 1-cycle latency, valid/ready I/O.
module otp_pad_engine
  import otp_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(OTP_POLY_8),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(OTP_SEED_8),
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_err,
  output logic [CNT_W-1:0]  pad_count,
  output logic              full
);

  logic [DATA_W-1:0] pad_mem_q [DEPTH];
  logic [DATA_W-1:0] pad_mem_d [DEPTH];
  logic [DEPTH-1:0]  slot_valid_q, slot_valid_d;
  logic [CNT_W-1:0]  pad_count_q, pad_count_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_err_q, out_err_d;

  logic [IDX_W-1:0]  free_idx;
  logic              any_free;
  logic              accept;

  otp_free_slot_enc #(.DEPTH(DEPTH)) u_free_slot_enc (
    .valid_bits (slot_valid_q),
    .free_idx   (free_idx),
    .any_free   (any_free)
  );

  assign in_ready  = ena && !flush && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_err   = out_err_q;
  assign pad_count = pad_count_q;
  assign full      = (pad_count_q == CNT_W'(DEPTH));

  always_comb begin
    pad_mem_d    = pad_mem_q;
    slot_valid_d = slot_valid_q;
    pad_count_d  = pad_count_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_err_d    = out_err_q;

    // The output handshake completes independently of flush and ena.
    if (out_ready) out_valid_d = 1'b0;

    if (flush) begin
      slot_valid_d = '0;
      pad_count_d  = '0;
      for (int i = 0; i < DEPTH; i++) pad_mem_d[i] = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      if (in_mode == OTP_ENC) begin
        if (any_free) begin
          out_data_d             = in_data ^ lfsr_q;
          out_idx_d              = free_idx;
          out_err_d              = 1'b0;
          pad_mem_d[free_idx]    = lfsr_q;
          slot_valid_d[free_idx] = 1'b1;
          pad_count_d            = pad_count_q + CNT_W'(1);
          lfsr_d = DATA_W'(lfsr_next(32'(lfsr_q), 32'(LFSR_POLY)));
        end else begin
          out_data_d = '0;
          out_idx_d  = '0;
          out_err_d  = 1'b1;
        end
      end else begin
        out_idx_d = in_idx;
        if (slot_valid_q[in_idx]) begin
          out_data_d           = in_data ^ pad_mem_q[in_idx];
          out_err_d            = 1'b0;
          pad_mem_d[in_idx]    = '0;
          slot_valid_d[in_idx] = 1'b0;
          pad_count_d          = pad_count_q - CNT_W'(1);
        end else begin
          out_data_d = '0;
          out_err_d  = 1'b1;
        end
      end
    end
  end

  // NOTE: the pad storage is reset along with the control state so that no
  // key material survives a reset; this costs a reset net on every pad bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pad_mem_q[i] <= '0;
      slot_valid_q <= '0;
      pad_count_q  <= '0;
      lfsr_q       <= LFSR_SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      pad_mem_q    <= pad_mem_d;
      slot_valid_q <= slot_valid_d;
      pad_count_q  <= pad_count_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule
